// File: rtl/arm9_shift_pkg.sv
// Shared encodings for the operand-2 shift path: controller states,
// request modes, shift-op codes and request decoding.
package arm9_shift_pkg;

  // Controller states (3-bit encoding)
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXEC    = 3'd1;
  localparam logic [2:0] ST_RS_REQ  = 3'd2;
  localparam logic [2:0] ST_RS_DATA = 3'd3;
  localparam logic [2:0] ST_VALID   = 3'd4;

  // Operand-2 request forms; code 2'b11 falls back to immediate shift
  localparam logic [1:0] MODE_IMM    = 2'b00;
  localparam logic [1:0] MODE_REG    = 2'b01;
  localparam logic [1:0] MODE_ROTIMM = 2'b10;

  // Shift operations (low two bits of the shifter type)
  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  // Decoded request as latched on accept
  typedef struct packed {
    logic [31:0] op;
    logic [7:0]  amount;
    logic [2:0]  typ;
    logic        is_reg;
  } shift_req_t;

  // Turn decode fields into shifter operands. type[2]=1 selects the
  // immediate-shift reading of amount 0 (LSR/ASR #32, ROR -> RRX);
  // type[2]=0 is the register-shift reading, also used for rotated
  // immediates so that rot=0 passes the operand and the C flag through.
  function automatic shift_req_t decode_req(
    input logic [1:0]  mode,
    input logic [1:0]  shift_op,
    input logic [31:0] op,
    input logic [4:0]  imm_amt
  );
    shift_req_t r;
    r.op     = op;
    r.amount = {3'b000, imm_amt};
    r.typ    = {1'b1, shift_op};
    r.is_reg = 1'b0;
    case (mode)
      MODE_REG: begin
        r.amount = 8'd0;
        r.typ    = {1'b0, shift_op};
        r.is_reg = 1'b1;
      end
      MODE_ROTIMM: begin
        r.op     = {24'd0, op[7:0]};
        r.amount = {3'b000, imm_amt[3:0], 1'b0};
        r.typ    = {1'b0, ROR};
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shifter.sv
// 32-bit barrel shifter with ARM carry semantics. type[2]=1 gives the
// immediate-shift interpretation of a zero amount, type[2]=0 the
// register-shift interpretation of an 8-bit amount.
module shifter
  import arm9_shift_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [7:0]  shift_amount,
  input  logic [2:0]  shift_type,
  input  logic        c,
  output logic [31:0] result,
  output logic        shift_c_out
);

  logic [4:0]  w_n5;
  logic        w_zero;
  logic        w_n5_zero;
  logic        w_lt32;
  logic        w_eq32;
  logic [32:0] w_lsl;
  logic [32:0] w_lsr;
  logic [32:0] w_asr;
  logic [31:0] w_ror;

  assign w_n5      = shift_amount[4:0];
  assign w_zero    = (shift_amount == 8'd0);
  assign w_n5_zero = (w_n5 == 5'd0);
  assign w_lt32    = (shift_amount < 8'd32);
  assign w_eq32    = (shift_amount == 8'd32);

  // Shifts by 1..31 carry the last bit shifted out in the extra bit
  assign w_lsl = {1'b0, op1} << w_n5;
  assign w_lsr = {op1, 1'b0} >> w_n5;
  assign w_asr = $signed({op1, 1'b0}) >>> w_n5;
  assign w_ror = (op1 >> w_n5) | (op1 << (6'd32 - {1'b0, w_n5}));

  // Select the result and carry for the requested form
  always_comb begin
    result      = op1;
    shift_c_out = c;
    if (shift_type[2]) begin
      case (shift_type[1:0])
        LSL: begin
          if (!w_n5_zero) begin
            result      = w_lsl[31:0];
            shift_c_out = w_lsl[32];
          end
        end
        LSR: begin
          if (w_n5_zero) begin
            result      = 32'd0;
            shift_c_out = op1[31];
          end else begin
            result      = w_lsr[32:1];
            shift_c_out = w_lsr[0];
          end
        end
        ASR: begin
          if (w_n5_zero) begin
            result      = {32{op1[31]}};
            shift_c_out = op1[31];
          end else begin
            result      = w_asr[32:1];
            shift_c_out = w_asr[0];
          end
        end
        default: begin
          if (w_n5_zero) begin
            result      = {c, op1[31:1]};
            shift_c_out = op1[0];
          end else begin
            result      = w_ror;
            shift_c_out = w_ror[31];
          end
        end
      endcase
    end else if (!w_zero) begin
      case (shift_type[1:0])
        LSL: begin
          if (w_lt32) begin
            result      = w_lsl[31:0];
            shift_c_out = w_lsl[32];
          end else begin
            result      = 32'd0;
            shift_c_out = w_eq32 ? op1[0] : 1'b0;
          end
        end
        LSR: begin
          if (w_lt32) begin
            result      = w_lsr[32:1];
            shift_c_out = w_lsr[0];
          end else begin
            result      = 32'd0;
            shift_c_out = w_eq32 ? op1[31] : 1'b0;
          end
        end
        ASR: begin
          if (w_lt32) begin
            result      = w_asr[32:1];
            shift_c_out = w_asr[0];
          end else begin
            result      = {32{op1[31]}};
            shift_c_out = op1[31];
          end
        end
        default: begin
          if (w_n5_zero) begin
            result      = op1;
            shift_c_out = op1[31];
          end else begin
            result      = w_ror;
            shift_c_out = w_ror[31];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// Operand-2 shift controller: accepts one decoded request per handshake,
// fetches Rs over the shared register-file port for register shifts,
// drives the barrel shifter and holds the registered result for the ALU.
module shift_ctrl
  import arm9_shift_pkg::*;
#(
  parameter int RS_ADDR_W = 4,
  parameter int AMT_W     = 8
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [1:0]           id_mode,
  input  logic [1:0]           id_shift_op,
  input  logic [31:0]          id_op,
  input  logic [4:0]           id_imm_amt,
  input  logic [RS_ADDR_W-1:0] id_rs_addr,
  input  logic                 cpsr_c,
  input  logic                 flush,
  output logic                 rs_rd_req,
  output logic [RS_ADDR_W-1:0] rs_rd_addr,
  input  logic                 rs_rd_gnt,
  input  logic [31:0]          rs_rd_data,
  output logic [31:0]          sh_op1,
  output logic [AMT_W-1:0]     sh_amount,
  output logic [2:0]           sh_type,
  output logic                 sh_c,
  input  logic [31:0]          sh_result,
  input  logic                 sh_c_out,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [31:0]          ex_op2,
  output logic                 ex_shc,
  output logic                 busy
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [31:0]            r_op;
  logic [AMT_W-1:0]       r_amount;
  logic [2:0]             r_type;
  logic [RS_ADDR_W-1:0]   r_rs_addr;
  logic [31:0]            r_ex_op2;
  logic                   r_ex_shc;

  shift_req_t             w_req;
  logic                   w_in_idle;
  logic                   w_in_valid;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_unused_rs_hi;

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_in_valid = (r_state == ST_VALID);

  // A new request may enter when empty or when the held result leaves
  // this cycle; a flush cycle never accepts.
  assign id_ready = ~flush & (w_in_idle | (w_in_valid & ex_ready));
  assign w_accept = id_valid & id_ready;
  assign w_req    = decode_req(id_mode, id_shift_op, id_op, id_imm_amt);

  // Shifter output is captured in the cycle the shifter is being driven
  assign w_capture = ~flush & ((r_state == ST_EXEC) | (r_state == ST_RS_DATA));

  // Only the low AMT_W bits of Rs form the shift amount
  assign w_unused_rs_hi = ^rs_rd_data[31:AMT_W];

  // Next-state selection; flush returns to IDLE from anywhere
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_req.is_reg ? ST_RS_REQ : ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_VALID;
      end
      ST_RS_REQ: begin
        if (rs_rd_gnt) begin
          w_state_next = ST_RS_DATA;
        end
      end
      ST_RS_DATA: begin
        w_state_next = ST_VALID;
      end
      ST_VALID: begin
        if (ex_ready) begin
          if (w_accept) begin
            w_state_next = w_req.is_reg ? ST_RS_REQ : ST_EXEC;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (flush) begin
      w_state_next = ST_IDLE;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch the decoded request operands on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= '0;
      r_amount  <= '0;
      r_type    <= '0;
      r_rs_addr <= '0;
    end else if (w_accept) begin
      r_op      <= w_req.op;
      r_amount  <= AMT_W'(w_req.amount);
      r_type    <= w_req.typ;
      r_rs_addr <= id_rs_addr;
    end
  end

  // Capture the shifter result; held unchanged while waiting on ex_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_op2 <= '0;
      r_ex_shc <= 1'b0;
    end else if (w_capture) begin
      r_ex_op2 <= sh_result;
      r_ex_shc <= sh_c_out;
    end
  end

  // Register-file read port
  assign rs_rd_req  = (r_state == ST_RS_REQ);
  assign rs_rd_addr = r_rs_addr;

  // Shifter drive: register-shift amount comes straight from the read data
  assign sh_op1    = r_op;
  assign sh_amount = (r_state == ST_RS_DATA) ? rs_rd_data[AMT_W-1:0] : r_amount;
  assign sh_type   = r_type;
  assign sh_c      = cpsr_c;

  // ALU-side handshake
  assign ex_valid = w_in_valid;
  assign ex_op2   = r_ex_op2;
  assign ex_shc   = r_ex_shc;
  assign busy     = ~w_in_idle;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed testbench for shift_ctrl driving a real shifter: a vector
// table of single requests plus hand-written stall, flush and reset
// sequences.
module tb_shift_ctrl;
  import arm9_shift_pkg::*;

  localparam int RS_ADDR_W = 4;
  localparam int AMT_W     = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 id_valid;
  logic                 id_ready;
  logic [1:0]           id_mode;
  logic [1:0]           id_shift_op;
  logic [31:0]          id_op;
  logic [4:0]           id_imm_amt;
  logic [RS_ADDR_W-1:0] id_rs_addr;
  logic                 cpsr_c;
  logic                 flush;
  logic                 rs_rd_req;
  logic [RS_ADDR_W-1:0] rs_rd_addr;
  logic                 rs_rd_gnt;
  logic [31:0]          rs_rd_data;
  logic [31:0]          sh_op1;
  logic [AMT_W-1:0]     sh_amount;
  logic [2:0]           sh_type;
  logic                 sh_c;
  logic [31:0]          sh_result;
  logic                 sh_c_out;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [31:0]          ex_op2;
  logic                 ex_shc;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_ctrl #(.RS_ADDR_W(RS_ADDR_W), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_mode(id_mode),
    .id_shift_op(id_shift_op), .id_op(id_op), .id_imm_amt(id_imm_amt),
    .id_rs_addr(id_rs_addr), .cpsr_c(cpsr_c), .flush(flush),
    .rs_rd_req(rs_rd_req), .rs_rd_addr(rs_rd_addr), .rs_rd_gnt(rs_rd_gnt),
    .rs_rd_data(rs_rd_data),
    .sh_op1(sh_op1), .sh_amount(sh_amount), .sh_type(sh_type), .sh_c(sh_c),
    .sh_result(sh_result), .sh_c_out(sh_c_out),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op2(ex_op2), .ex_shc(ex_shc),
    .busy(busy)
  );

  shifter u_shifter (
    .op1(sh_op1), .shift_amount(sh_amount), .shift_type(sh_type), .c(sh_c),
    .result(sh_result), .shift_c_out(sh_c_out)
  );

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [1:0]  sop;
    logic [31:0] op;
    logic [4:0]  imm;
    logic [3:0]  rs_addr;
    logic [31:0] rs_val;
    logic        cpsr;
    int          gwait;
    logic [31:0] e_op2;
    logic        e_shc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic [1:0] mode, input logic [1:0] sop,
                     input logic [31:0] op, input logic [4:0] imm, input logic [3:0] rsa,
                     input logic [31:0] rsv, input logic cp, input int gw,
                     input logic [31:0] eop2, input logic eshc);
    vec_t v;
    v.name = nm; v.mode = mode; v.sop = sop; v.op = op; v.imm = imm;
    v.rs_addr = rsa; v.rs_val = rsv; v.cpsr = cp; v.gwait = gw;
    v.e_op2 = eop2; v.e_shc = eshc;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // One request from accept to consumption, with a modelled read port
  task automatic run_vec(input vec_t v);
    int   lat;
    int   wcnt;
    int   exp_lat;
    logic gprev;
    exp_lat     = (v.mode == MODE_REG) ? 3 + v.gwait : 2;
    id_valid    = 1'b1;
    id_mode     = v.mode;
    id_shift_op = v.sop;
    id_op       = v.op;
    id_imm_amt  = v.imm;
    id_rs_addr  = v.rs_addr;
    cpsr_c      = v.cpsr;
    ex_ready    = 1'b1;
    rs_rd_gnt   = 1'b0;
    rs_rd_data  = 32'hDEADBEEF;
    #1;
    check({v.name, ".id_ready"}, {31'd0, id_ready}, 32'd1);
    tick();
    // Scramble decode inputs so only latched values can produce the result
    id_valid    = 1'b0;
    id_op       = 32'h5555AAAA;
    id_imm_amt  = 5'd17;
    id_shift_op = ~v.sop;
    id_rs_addr  = ~v.rs_addr;
    lat   = 1;
    wcnt  = 0;
    gprev = 1'b0;
    while (!ex_valid && lat < 40) begin
      rs_rd_data = gprev ? v.rs_val : 32'hDEADBEEF;
      if (rs_rd_req) begin
        check({v.name, ".rs_addr"}, {28'd0, rs_rd_addr}, {28'd0, v.rs_addr});
        rs_rd_gnt = (wcnt == v.gwait);
        wcnt++;
      end else begin
        rs_rd_gnt = 1'b0;
      end
      gprev = rs_rd_gnt;
      tick();
      lat++;
    end
    rs_rd_gnt  = 1'b0;
    rs_rd_data = 32'hDEADBEEF;
    check({v.name, ".latency"}, lat, exp_lat);
    check({v.name, ".ex_op2"}, ex_op2, v.e_op2);
    check({v.name, ".ex_shc"}, {31'd0, ex_shc}, {31'd0, v.e_shc});
    $display("vec %-14s op2=0x%08h shc=%0d latency=%0d", v.name, ex_op2, ex_shc, lat);
    tick();
    check({v.name, ".consumed"}, {31'd0, ex_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_mode = 2'b00; id_shift_op = 2'b00;
    id_op = '0; id_imm_amt = '0; id_rs_addr = '0; cpsr_c = 1'b0; flush = 1'b0;
    rs_rd_gnt = 1'b0; rs_rd_data = '0; ex_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.rs_rd_req", {31'd0, rs_rd_req}, 32'd0);
    check("rst.ex_op2", ex_op2, 32'd0);
    check("rst.ex_shc", {31'd0, ex_shc}, 32'd0);
    check("rst.id_ready", {31'd0, id_ready}, 32'd1);

    //   name            mode        sop  op            imm     rsa   rs_val        c   gw  exp_op2       shc
    add("imm_lsl4",      MODE_IMM,    LSL, 32'h000000F1, 5'd4,  4'd0, 32'h0,        1, 0, 32'h00000F10, 0);
    add("imm_lsr32",     MODE_IMM,    LSR, 32'h80000000, 5'd0,  4'd0, 32'h0,        0, 0, 32'h00000000, 1);
    add("imm_rrx",       MODE_IMM,    ROR, 32'h00000001, 5'd0,  4'd0, 32'h0,        1, 0, 32'h80000000, 1);
    add("imm_asr32",     MODE_IMM,    ASR, 32'h7FFFFFFF, 5'd0,  4'd0, 32'h0,        1, 0, 32'h00000000, 0);
    add("imm_lsl0",      MODE_IMM,    LSL, 32'h00001234, 5'd0,  4'd0, 32'h0,        1, 0, 32'h00001234, 1);
    add("mode11_lsr4",   2'b11,       LSR, 32'h000000F8, 5'd4,  4'd0, 32'h0,        0, 0, 32'h0000000F, 1);
    add("reg_ror_wait3", MODE_REG,    ROR, 32'h12345678, 5'd0,  4'd9, 32'h00000108, 0, 3, 32'h78123456, 0);
    add("reg_lsl0",      MODE_REG,    LSL, 32'hCAFEF00D, 5'd0,  4'd2, 32'h00000000, 1, 0, 32'hCAFEF00D, 1);
    add("reg_lsl64",     MODE_REG,    LSL, 32'hFFFFFFFF, 5'd0,  4'd3, 32'h00000040, 1, 0, 32'h00000000, 0);
    add("reg_lsr32",     MODE_REG,    LSR, 32'h80000000, 5'd0,  4'd4, 32'h00000020, 0, 0, 32'h00000000, 1);
    add("reg_asr255",    MODE_REG,    ASR, 32'h80000000, 5'd0,  4'd5, 32'h000000FF, 0, 2, 32'hFFFFFFFF, 1);
    add("reg_lsl33",     MODE_REG,    LSL, 32'hFFFFFFFF, 5'd0,  4'd6, 32'h00000021, 1, 0, 32'h00000000, 0);
    add("reg_ror32",     MODE_REG,    ROR, 32'h80000001, 5'd0,  4'd7, 32'hFFFFFF20, 0, 0, 32'h80000001, 1);
    add("reg_lsr1",      MODE_REG,    LSR, 32'h00000003, 5'd0,  4'd8, 32'h00000001, 0, 1, 32'h00000001, 1);
    add("rot_ff_r4",     MODE_ROTIMM, LSL, 32'hABCDEFFF, 5'd20, 4'd0, 32'h0,        0, 0, 32'hFF000000, 1);
    add("rot0_c0",       MODE_ROTIMM, ASR, 32'h0000005A, 5'd0,  4'd0, 32'h0,        0, 0, 32'h0000005A, 0);
    add("rot0_c1",       MODE_ROTIMM, ASR, 32'h0000005A, 5'd16, 4'd0, 32'h0,        1, 0, 32'h0000005A, 1);

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i]);
    end

    // ALU stall for 3 cycles, then back-to-back accept on the ex_ready cycle
    ex_ready = 1'b0; cpsr_c = 1'b0;
    id_valid = 1'b1; id_mode = MODE_IMM; id_shift_op = LSL; id_op = 32'h1; id_imm_amt = 5'd1;
    tick();
    id_valid = 1'b0;
    tick();
    check("stall.ex_valid", {31'd0, ex_valid}, 32'd1);
    check("stall.ex_op2", ex_op2, 32'h2);
    id_valid = 1'b1; id_shift_op = LSR; id_op = 32'h3; id_imm_amt = 5'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall.id_ready", {31'd0, id_ready}, 32'd0);
      check("stall.hold_op2", ex_op2, 32'h2);
      check("stall.hold_shc", {31'd0, ex_shc}, 32'd0);
      check("stall.hold_valid", {31'd0, ex_valid}, 32'd1);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    check("b2b.id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    id_valid = 1'b0;
    check("b2b.exec_valid", {31'd0, ex_valid}, 32'd0);
    check("b2b.exec_busy", {31'd0, busy}, 32'd1);
    tick();
    check("b2b.ex_valid", {31'd0, ex_valid}, 32'd1);
    check("b2b.ex_op2", ex_op2, 32'h1);
    check("b2b.ex_shc", {31'd0, ex_shc}, 32'd1);
    $display("seq stall_b2b op2=0x%08h shc=%0d", ex_op2, ex_shc);
    tick();
    check("b2b.idle", {31'd0, busy}, 32'd0);

    // Flush while waiting for the read port; grant and request in that cycle are ignored
    id_valid = 1'b1; id_mode = MODE_REG; id_shift_op = LSL; id_op = 32'hF; id_rs_addr = 4'd5;
    tick();
    id_valid = 1'b0;
    check("flush.rs_rd_req", {31'd0, rs_rd_req}, 32'd1);
    flush = 1'b1; rs_rd_gnt = 1'b1; rs_rd_data = 32'h1;
    id_valid = 1'b1; id_mode = MODE_IMM;
    #1;
    check("flush.id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    flush = 1'b0; rs_rd_gnt = 1'b0; id_valid = 1'b0;
    check("flush.req_drop", {31'd0, rs_rd_req}, 32'd0);
    check("flush.busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("flush.no_valid", {31'd0, ex_valid}, 32'd0);
      tick();
    end
    $display("seq flush_rs_req busy=%0d ex_valid=%0d", busy, ex_valid);

    // Reset while a result is held
    ex_ready = 1'b0; cpsr_c = 1'b1;
    id_valid = 1'b1; id_mode = MODE_IMM; id_shift_op = LSL; id_op = 32'hF1; id_imm_amt = 5'd4;
    tick();
    id_valid = 1'b0;
    tick();
    check("rstv.pre_valid", {31'd0, ex_valid}, 32'd1);
    check("rstv.pre_op2", ex_op2, 32'hF10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstv.ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rstv.busy", {31'd0, busy}, 32'd0);
    check("rstv.ex_op2", ex_op2, 32'd0);
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rstv.no_valid", {31'd0, ex_valid}, 32'd0);
    end
    $display("seq reset_in_valid ex_valid=%0d op2=0x%08h", ex_valid, ex_op2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
Sequences the 32-bit barrel shifter (`shifter`) for the operand-2 path of data-processing instructions. It takes one decoded request per handshake and handles three forms: immediate-shift, register-specified shift, and rotated 8-bit immediate. For register shifts it obtains Rs through the shared register-file read port, which costs extra cycles. It registers the shifted operand and carry for the ALU stage behind a valid/ready handshake.

Parameters:
RS_ADDR_W, 4, register-file address width for the Rs read port
AMT_W, 8, shift-amount width (Rs[7:0])

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  decode presents a request
id_ready  output  1  controller accepts request this cycle
id_mode  input  2  00 imm-shift, 01 reg-shift, 10 rotated-imm, 11 treated as imm-shift
id_shift_op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
id_op  input  32  Rm value; for rotated-imm, bits [7:0] = imm8
id_imm_amt  input  5  imm shift amount; for rotated-imm, bits [3:0] = rot
id_rs_addr  input  RS_ADDR_W  Rs index for reg-shift
cpsr_c  input  1  current C flag
flush  input  1  synchronous pipeline flush
rs_rd_req  output  1  request shared read port
rs_rd_addr  output  RS_ADDR_W  Rs index, stable while rs_rd_req is high
rs_rd_gnt  input  1  port granted this cycle; data returns next cycle
rs_rd_data  input  32  Rs value, valid the cycle after grant
sh_op1  output  32  to shifter op1
sh_amount  output  AMT_W  to shifter shift_amount
sh_type  output  3  to shifter shift_type
sh_c  output  1  to shifter C
sh_result  input  32  from shifter result
sh_c_out  input  1  from shifter shift_c_out
ex_valid  output  1  shifted operand valid
ex_ready  input  1  ALU stage accepts
ex_op2  output  32  registered shifter result
ex_shc  output  1  registered shifter carry
busy  output  1  state != IDLE

Behaviour:
- Clocking and reset:
  - Single clock. reset is synchronous and active-high.
  - All registers update on the clk rising edge.
- State machine: 3-bit state IDLE, EXEC, RS_REQ, RS_DATA, VALID.
- Reset values:
  - state = IDLE.
  - ex_valid, rs_rd_req, busy = 0.
  - ex_op2 = 0, ex_shc = 0, internal op/amount/type registers = 0.
- id_ready = (state==IDLE) | (state==VALID & ex_ready), gated low by flush.
- Accept = id_valid & id_ready. On accept, latch op, type and amount:
  - Imm-shift: op = id_op; amount = {3'b0, id_imm_amt}; type = {1'b1, id_shift_op}. The type[2]=1 encoding makes LSR/ASR #0 mean #32 and ROR #0 mean RRX. Next state EXEC.
  - Rotated-imm: op = {24'b0, id_op[7:0]}; amount = {3'b0, id_imm_amt[3:0], 1'b0}; type = 3'b011. Next state EXEC. With rot=0 the carry is cpsr_c.
  - Reg-shift: op = id_op; type = {1'b0, id_shift_op}; latch id_rs_addr. Next state RS_REQ.
- EXEC:
  - Drive sh_op1, sh_amount and sh_type from the registers; sh_c = cpsr_c (sampled this cycle).
  - Capture sh_result and sh_c_out into ex_op2 and ex_shc. Next state VALID.
- RS_REQ:
  - rs_rd_req = 1, rs_rd_addr = latched Rs.
  - Stay until rs_rd_gnt, then go to RS_DATA. No cycle limit.
- RS_DATA:
  - rs_rd_req = 0; sh_amount = rs_rd_data[7:0] combinationally.
  - Capture result and carry as in EXEC. Next state VALID.
  - Amounts of 0 and amounts of 32 or more follow the shifter semantics exactly; the controller does not saturate.
- VALID:
  - ex_valid = 1; ex_op2 and ex_shc are held stable until ex_ready.
  - On ex_ready with a new accept in the same cycle, proceed to EXEC or RS_REQ. On ex_ready without an accept, go to IDLE.
- Latency:
  - Imm and rotated-imm: accept in cycle N, ex_valid in N+2.
  - Reg-shift: accept in N, earliest grant in N+1, ex_valid in N+3; each cycle of grant delay adds one cycle.
- Flush:
  - Next state IDLE from any state. rs_rd_req drops next cycle; a grant arriving in the flush cycle is ignored.
  - ex_valid clears next cycle. No accept occurs in the flush cycle.
- Reset overrides flush. Reset mid-operation discards everything and no ex_valid follows.
- sh_* outputs are don't-care in IDLE, RS_REQ and VALID, but must be deterministic (registered values).

Decomposition:
- Package arm9_shift_pkg holds:
  - state encodings (IDLE=0, EXEC=1, RS_REQ=2, RS_DATA=3, VALID=4);
  - mode codes (MODE_IMM, MODE_REG, MODE_ROTIMM);
  - shift-op codes (LSL, LSR, ASR, ROR).
- The testbench instantiates `shifter` alongside shift_ctrl. No other sub-module; the FSM and registers live in shift_ctrl.

Test Plan:
1. Imm LSL#4, id_op=0x000000F1, cpsr_c=1 -> ex_op2=0x00000F10, ex_shc=0, ex_valid at N+2.
2. Imm LSR#0 (meaning #32), id_op=0x80000000 -> ex_op2=0x00000000, ex_shc=1. Imm ROR#0 (RRX) with id_op=0x00000001, cpsr_c=1 -> ex_op2=0x80000000, ex_shc=1.
3. Reg ROR, Rs=0x00000108, id_op=0x12345678, grant withheld 3 cycles -> rs_rd_req held high with stable rs_rd_addr; ex_op2=0x78123456, ex_shc=0; ex_valid 2 cycles after grant.
4. Reg LSL with Rs=0 and cpsr_c=1 -> ex_op2=id_op, ex_shc=1. Reg LSL with Rs=0x40 -> ex_op2=0, ex_shc=0.
5. Rotated-imm imm8=0xFF, rot=4 -> ex_op2=0xFF000000, ex_shc=1.
6. ex_ready low 3 cycles holds ex_op2/ex_shc stable; back-to-back accept on the ex_ready cycle. Flush in RS_REQ -> IDLE next cycle, rs_rd_req=0, no ex_valid. Reset in VALID -> ex_valid=0 next cycle.
